// File: rtl/timer_pkg.sv
// Shared types and helpers for countdown_timer and its tick generator.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // A single-cycle prescale still needs a 1-bit vector to keep port widths legal.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; clear restarts the phase.
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);

    generate
        if (PRESCALE <= 1) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clear};
            assign tick      = enable;
        end else begin : g_cnt
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q;
            logic [PW-1:0] pre_d;

            always_comb begin
                pre_d = pre_q;
                if (clear) begin
                    pre_d = '0;
                end else if (enable) begin
                    pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            assign tick = enable && !clear && (pre_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter of prescaled ticks with expiry flag.
// Optional periodic mode when AUTO_RELOAD_EN is defined.
//
// state | meaning
// IDLE  | holding count, waiting for start
// RUN   | counting down on each prescaled tick while enable is high
// DONE  | expired, count is 0, waits for load or abort
module countdown_timer
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  expired
);

    timer_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  expired_q, expired_d;
    logic                  tick;
    logic                  tick_en;
    logic                  tick_clear;
`ifdef AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
`endif

    // Prescaler phase restarts whenever RUN is entered, so decrements land on E+k*PRESCALE.
    assign tick_en    = (state_q == RUN) && enable && !load && !abort;
    assign tick_clear = (state_q != RUN) || load || abort;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .enable(tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        if (load) begin
            state_d = IDLE;
            count_d = load_value;
`ifdef AUTO_RELOAD_EN
            reload_d = load_value;
`endif
        end else if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_q <= DATA_WIDTH'(1)) begin
                            expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end else begin
                            count_d = count_q - DATA_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
`ifdef AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign expired = expired_q;

endmodule
